bcd_updown_counter_n: RTL and testbench



---
 rtl/bcd_updown_counter_n.sv | 76 +++++++
 tb/tb_bcd_updown_counter_n.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: multi-digit radix-MOD up/down counter with validated load, saturate/wrap, compare match and cascade carry
module bcd_updown_counter_n #(
    parameter int DIGITS   = 4,
    parameter int MOD      = 10,
    parameter int SATURATE = 0
) (
    input  logic                  clkin,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  en,
    input  logic                  upd,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [4*DIGITS-1:0]   cmp,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CO,
    output logic                  match,
    output logic                  err
);
    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] MAXD = 4'(MOD - 1);
    localparam logic [4:0] MODV = 5'(MOD);

    logic [W-1:0] q_q, q_d, cnt;
    logic         match_q, match_d, err_q, err_d;
    logic         all_max, all_zero, ok, term;
    logic [3:0]   dig;

    // per-digit ripple: each digit steps only when every lower digit sits at its rollover value
    always_comb begin
        cnt      = q_q;
        all_max  = 1'b1;
        all_zero = 1'b1;
        ok       = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_q[4*i +: 4];
            cnt[4*i +: 4] = upd ? (all_max ? (dig == MAXD ? 4'd0 : dig + 4'd1) : dig)
                                : (all_zero ? (dig == 4'd0 ? MAXD : dig - 4'd1) : dig);
            all_max  = all_max & (dig == MAXD);
            all_zero = all_zero & (dig == 4'd0);
            ok       = ok & ({1'b0, data[4*i +: 4]} < MODV);
        end
    end

    // next state: load beats count; an invalid load keeps Q and raises err for one edge
    always_comb begin
        term    = upd ? all_max : all_zero;
        q_d     = q_q;
        err_d   = 1'b0;
        match_d = (q_q == cmp);
        if (!load) begin
            q_d   = ok ? data : q_q;
            err_d = !ok;
        end else if (en && !(SATURATE != 0 && term)) begin
            q_d = cnt;
        end
    end

    // state registers, cleared asynchronously by clr
    always_ff @(posedge clkin or negedge clr) begin
        if (!clr) begin
            q_q     <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign Q     = q_q;
    assign match = match_q;
    assign err   = err_q;
    assign CO    = clr & load & en & (upd ? all_max : all_zero);
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: directed scoreboard bench for bcd_updown_counter_n
module tb_bcd_updown_counter_n;
    logic        clkin = 1'b0;
    logic        clr, load, en, upd;
    logic [15:0] data, cmp, q0, q1;
    logic [7:0]  q2;
    logic        co0, co1, co2, m0, m1, m2, e0, e1, e2;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clkin = ~clkin;

    bcd_updown_counter_n #(.DIGITS(4), .MOD(10), .SATURATE(0)) u0 (
        .clkin(clkin), .clr(clr), .load(load), .en(en), .upd(upd),
        .data(data), .cmp(cmp), .Q(q0), .CO(co0), .match(m0), .err(e0)
    );

    bcd_updown_counter_n #(.DIGITS(4), .MOD(10), .SATURATE(1)) u1 (
        .clkin(clkin), .clr(clr), .load(load), .en(en), .upd(upd),
        .data(data), .cmp(cmp), .Q(q1), .CO(co1), .match(m1), .err(e1)
    );

    bcd_updown_counter_n #(.DIGITS(2), .MOD(6), .SATURATE(0)) u2 (
        .clkin(clkin), .clr(clr), .load(load), .en(en), .upd(upd),
        .data(data[7:0]), .cmp(cmp[7:0]), .Q(q2), .CO(co2), .match(m2), .err(e2)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h with nothing expected", got);
        end else begin
            e = sb.pop_front();
            assert (got === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b0; load = 1'b1; en = 1'b0; upd = 1'b1; data = '0; cmp = '0;
        push("reset_q", 0); push("reset_match", 0); push("reset_err", 0); push("reset_co", 0);
        #1;
        pop_chk(q0); pop_chk(m0); pop_chk(e0); pop_chk(co0);
        // load 0457 then count once; cmp set so match rises, then async abort
        clr = 1'b1; load = 1'b0; data = 16'h0457; cmp = 16'h0457;
        push("load_0457", 16'h0457);
        tick(); pop_chk(q0);
        load = 1'b1; en = 1'b1;
        push("count_0458", 16'h0458); push("match_pre_abort", 1);
        tick(); pop_chk(q0); pop_chk(m0);
        #2 clr = 1'b0;
        push("abort_q", 0); push("abort_match", 0); push("abort_err", 0);
        #1;
        pop_chk(q0); pop_chk(m0); pop_chk(e0);
        clr = 1'b1; cmp = 16'h0000;
        // load 0999 and step up to 1000
        load = 1'b0; data = 16'h0999;
        push("load_0999", 16'h0999); push("co_during_load_0999", 0);
        tick(); pop_chk(q0); pop_chk(co0);
        load = 1'b1;
        push("co_at_0999", 0);
        #1 pop_chk(co0);
        push("up_1000", 16'h1000);
        tick(); pop_chk(q0);
        // terminal up count: wrap vs saturate
        load = 1'b0; data = 16'h9999;
        push("load_9999_u0", 16'h9999); push("load_9999_u1", 16'h9999); push("co_low_while_load", 0);
        tick(); pop_chk(q0); pop_chk(q1); pop_chk(co0);
        load = 1'b1;
        push("co_up_term_u0", 1); push("co_up_term_u1", 1);
        #1 pop_chk(co0); pop_chk(co1);
        push("wrap_up_0000", 16'h0000); push("sat_up_9999", 16'h9999);
        tick(); pop_chk(q0); pop_chk(q1);
        // down counting with borrow across digits and terminal down
        load = 1'b0; data = 16'h1000; upd = 1'b0;
        push("load_1000", 16'h1000);
        tick(); pop_chk(q0);
        load = 1'b1;
        push("down_0999", 16'h0999);
        tick(); pop_chk(q0);
        load = 1'b0; data = 16'h0000;
        push("load_0000_u0", 0); push("load_0000_u1", 0);
        tick(); pop_chk(q0); pop_chk(q1);
        load = 1'b1;
        push("co_down_term_u0", 1); push("co_down_term_u1", 1);
        #1 pop_chk(co0); pop_chk(co1);
        push("wrap_down_9999", 16'h9999); push("sat_down_0000", 16'h0000);
        tick(); pop_chk(q0); pop_chk(q1);
        // invalid load rejected, err pulses once; en=0 holds regardless of upd
        load = 1'b0; data = 16'h12A4;
        push("bad_load_q", 16'h9999); push("bad_load_err", 1);
        tick(); pop_chk(q0); pop_chk(e0);
        load = 1'b1; en = 1'b0; upd = 1'b1;
        push("hold_q", 16'h9999); push("err_clears", 0);
        tick(); pop_chk(q0); pop_chk(e0);
        upd = 1'b0;
        push("hold_upd_flip", 16'h9999);
        tick(); pop_chk(q0);
        load = 1'b0; en = 1'b1; upd = 1'b1; data = 16'h0042;
        push("load_over_en", 16'h0042); push("good_load_err", 0);
        tick(); pop_chk(q0); pop_chk(e0);
        // compare match latency
        data = 16'h0003; cmp = 16'h0005;
        push("load_0003", 16'h0003);
        tick(); pop_chk(q0);
        load = 1'b1;
        push("up_0004", 16'h0004); push("match_at_0003", 0);
        tick(); pop_chk(q0); pop_chk(m0);
        push("up_0005", 16'h0005); push("match_at_0004", 0);
        tick(); pop_chk(q0); pop_chk(m0);
        push("up_0006", 16'h0006); push("match_after_0005", 1);
        tick(); pop_chk(q0); pop_chk(m0);
        en = 1'b0;
        push("match_drops", 0);
        tick(); pop_chk(m0);
        // radix-6 two-digit instance
        load = 1'b0; data = 16'h0055;
        push("mod6_load_55", 8'h55);
        tick(); pop_chk(q2);
        load = 1'b1; en = 1'b1;
        push("mod6_co_up", 1); push("co_u0_not_term", 0);
        #1 pop_chk(co2); pop_chk(co0);
        push("mod6_wrap_00", 8'h00); push("u0_up_0056", 16'h0056);
        tick(); pop_chk(q2); pop_chk(q0);
        upd = 1'b0;
        push("mod6_co_down", 1);
        #1 pop_chk(co2);
        push("mod6_wrap_55", 8'h55);
        tick(); pop_chk(q2);
        load = 1'b0; data = 16'h0046;
        push("mod6_bad_err", 1); push("mod6_bad_q", 8'h55); push("u0_load_0046", 16'h0046); push("u0_load_0046_err", 0);
        tick(); pop_chk(e2); pop_chk(q2); pop_chk(q0); pop_chk(e0);
        load = 1'b1; en = 1'b0;
        push("mod6_err_clears", 0);
        tick(); pop_chk(e2);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
